// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared constants and types for the cursor overlay: sprite geometry, screen limits,
// transparent key colour and the coordinate clamp helper.
package mouse_cursor_overlay_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [23:0] rgb_t;

  localparam int unsigned CURSOR_W = 60;
  localparam int unsigned CURSOR_H = 60;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam rgb_t        KEY_RGB  = 24'hFF00FF;

  localparam coord_t X_MAX  = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_MAX  = coord_t'(V_ACTIVE - 1);
  localparam coord_t X_HOME = coord_t'(H_ACTIVE / 2);
  localparam coord_t Y_HOME = coord_t'(V_ACTIVE / 2);

  function automatic coord_t clamp_coord(input coord_t v, input coord_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/mouse_cursor_overlay_cursor_pos_sync.sv
// Cursor position latch: clamped shadow register, frame-synchronous commit with bypass,
// and (with CURSOR_HIDE_TIMEOUT_EN) an idle-frame counter that hides a static cursor.
module cursor_pos_sync
  import mouse_cursor_overlay_pkg::*;
  #(parameter int unsigned HIDE_FRAMES = 180)
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   frame_start,
  input  logic   mouse_valid,
  input  coord_t mouse_x,
  input  coord_t mouse_y,
  output coord_t ax,
  output coord_t ay,
  output logic   visible
);

  coord_t cx, cy;
  coord_t sx, sy;
  coord_t nx, ny;

  assign cx = clamp_coord(mouse_x, X_MAX);
  assign cy = clamp_coord(mouse_y, Y_MAX);

  // Value committed on frame_start; a same-cycle update bypasses the shadow.
  assign nx = mouse_valid ? cx : sx;
  assign ny = mouse_valid ? cy : sy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx <= X_HOME;
      sy <= Y_HOME;
      ax <= X_HOME;
      ay <= Y_HOME;
    end else begin
      if (mouse_valid) begin
        sx <= cx;
        sy <= cy;
      end
      if (frame_start) begin
        ax <= nx;
        ay <= ny;
      end
    end
  end

`ifdef CURSOR_HIDE_TIMEOUT_EN
  localparam logic [7:0] HIDE_MAX = 8'(HIDE_FRAMES);

  logic [7:0] idle_cnt;
  logic       moved;

  assign moved = (nx != ax) || (ny != ay);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idle_cnt <= '0;
    end else if (frame_start) begin
      if (moved)
        idle_cnt <= '0;
      else if (idle_cnt < HIDE_MAX)
        idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign visible = (idle_cnt < HIDE_MAX);
`else
  assign visible = 1'b1;
`endif

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Per-pixel cursor overlay: ROM address generation, 2-stage pipeline and key-colour
// compositing. Optional auto-hide is enabled by defining CURSOR_HIDE_TIMEOUT_EN.
module mouse_cursor_overlay
  import mouse_cursor_overlay_pkg::*;
  #(parameter int unsigned HIDE_FRAMES = 180)
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        mouse_valid,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [23:0] bg_rgb,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [23:0] out_rgb,
  output logic        out_valid,
  output logic        cursor_hit
);

  coord_t      ax, ay;
  logic        visible;
  logic [10:0] x_end, y_end;
  logic        in_box;
  coord_t      dx, dy;

  logic        v1, hit1;
  rgb_t        bg1;
  logic        show;

  cursor_pos_sync #(.HIDE_FRAMES(HIDE_FRAMES)) u_pos (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .mouse_valid (mouse_valid),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .ax          (ax),
    .ay          (ay),
    .visible     (visible)
  );

  // 11-bit box edges so a cursor near the right/bottom edge never wraps.
  assign x_end  = {1'b0, ax} + 11'(CURSOR_W);
  assign y_end  = {1'b0, ay} + 11'(CURSOR_H);
  assign in_box = (DrawX >= ax) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= ay) && ({1'b0, DrawY} < y_end);

  assign dx = DrawX - ax;
  assign dy = DrawY - ay;

  always_comb begin
    rom_addr = '0;
    if (pixel_valid && in_box)
      rom_addr = 16'(dy) * 16'(CURSOR_W) + 16'(dx);
  end

  assign show = hit1 && visible && (rom_data != KEY_RGB);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1         <= 1'b0;
      hit1       <= 1'b0;
      bg1        <= '0;
      out_valid  <= 1'b0;
      cursor_hit <= 1'b0;
      out_rgb    <= '0;
    end else begin
      v1         <= pixel_valid;
      hit1       <= pixel_valid && in_box;
      bg1        <= bg_rgb;
      out_valid  <= v1;
      cursor_hit <= hit1 && visible;
      out_rgb    <= v1 ? (show ? rom_data : bg1) : '0;
    end
  end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Bench for mouse_cursor_overlay: table vectors, directed corner sequences and random
// stimulus checked against a coordinate-level reference model with a 2-deep latency queue.
module tb_mouse_cursor_overlay;

  localparam int SPR    = 60;
  localparam int SCR_W  = 640;
  localparam int SCR_H  = 480;
  localparam logic [23:0] KEY = 24'hFF00FF;
`ifdef CURSOR_HIDE_TIMEOUT_EN
  localparam int HIDE = 3;
`else
  localparam int HIDE = 180;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        mouse_valid = 1'b0;
  logic [9:0]  mouse_x = '0;
  logic [9:0]  mouse_y = '0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [23:0] bg_rgb = '0;
  logic [15:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic [23:0] out_rgb;
  logic        out_valid;
  logic        cursor_hit;

  mouse_cursor_overlay #(.HIDE_FRAMES(HIDE)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .mouse_valid (mouse_valid),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .pixel_valid (pixel_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .bg_rgb      (bg_rgb),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_rgb     (out_rgb),
    .out_valid   (out_valid),
    .cursor_hit  (cursor_hit)
  );

  always #5 Clk = ~Clk;

  logic [23:0] rom_mem [0:3599];
  always @(posedge Clk)
    rom_data <= (rom_addr < 16'd3600) ? rom_mem[rom_addr] : 24'h0;

  typedef struct {
    bit          v;
    logic [23:0] rgb;
    bit          hit;
  } exp_t;

  typedef struct {
    int          x;
    int          y;
    bit          pv;
    logic [23:0] bg;
    int          addr;
    bit          hit;
  } vec_t;

  exp_t pend[$];
  int   sh_x, sh_y, ac_x, ac_y, idle;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int clampi(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; outputs are checked for the pixel issued two cycles earlier.
  task automatic apply(input bit rst, input bit fs, input bit mv, input int mx, input int my,
                       input bit pv, input int px, input int py, input logic [23:0] bg,
                       input bit use_tab, input int tab_addr, input bit tab_hit);
    exp_t e;
    int   eaddr, nx, ny;
    bit   ein, evis;
    @(negedge Clk);
    if (pend.size() == 2) begin
      e = pend.pop_front();
      check("out_valid", out_valid, e.v);
      check("cursor_hit", cursor_hit, e.hit);
      check("out_rgb", out_rgb, e.rgb);
    end
    Reset = rst; frame_start = fs; mouse_valid = mv;
    mouse_x = 10'(mx); mouse_y = 10'(my);
    pixel_valid = pv; DrawX = 10'(px); DrawY = 10'(py); bg_rgb = bg;
    #1;
    ein = pv && px >= ac_x && px < ac_x + SPR && py >= ac_y && py < ac_y + SPR;
    eaddr = ein ? (py - ac_y) * SPR + (px - ac_x) : 0;
    if (use_tab) begin
      eaddr = tab_addr;
      ein   = tab_hit;
    end
    check("rom_addr", rom_addr, eaddr);
    evis = 1'b1;
`ifdef CURSOR_HIDE_TIMEOUT_EN
    evis = (idle < HIDE);
`endif
    e.v   = pv;
    e.hit = ein && evis;
    e.rgb = !pv ? 24'h0 : ((e.hit && rom_mem[eaddr] != KEY) ? rom_mem[eaddr] : bg);
    if (rst) begin
      foreach (pend[i]) pend[i] = '{v: 1'b0, rgb: 24'h0, hit: 1'b0};
      e = '{v: 1'b0, rgb: 24'h0, hit: 1'b0};
      sh_x = SCR_W / 2; sh_y = SCR_H / 2;
      ac_x = SCR_W / 2; ac_y = SCR_H / 2;
      idle = 0;
    end else begin
      if (fs) begin
        nx = mv ? clampi(mx, SCR_W) : sh_x;
        ny = mv ? clampi(my, SCR_H) : sh_y;
        if (nx == ac_x && ny == ac_y) idle = idle + 1;
        else                          idle = 0;
`ifdef CURSOR_HIDE_TIMEOUT_EN
        if (idle > HIDE) idle = HIDE;
`endif
        ac_x = nx; ac_y = ny;
      end
      if (mv) begin
        sh_x = clampi(mx, SCR_W);
        sh_y = clampi(my, SCR_H);
      end
    end
    pend.push_back(e);
  endtask

  task automatic pix(input int px, input int py, input logic [23:0] bg);
    apply(0, 0, 0, 0, 0, 1, px, py, bg, 0, 0, 0);
  endtask

  task automatic tpix(input int px, input int py, input int a, input bit h);
    apply(0, 0, 0, 0, 0, 1, px, py, 24'h00C0DE + 24'(a), 1, a, h);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
  endtask

  vec_t tab[9];

  initial begin
    int r, px, py, mx, my;
    bit rst, fs, mv, pv;

    for (int i = 0; i < 3600; i++) begin
      rom_mem[i] = 24'($urandom);
      if (i % 97 == 13) rom_mem[i] = KEY;
    end
    rom_mem[0]    = 24'h00A0B0;
    rom_mem[61]   = KEY;
    rom_mem[559]  = 24'h654321;
    rom_mem[3599] = 24'h123456;

    tab[0] = '{x: 320, y: 240, pv: 1, bg: 24'h111111, addr: 0,    hit: 1};
    tab[1] = '{x: 379, y: 299, pv: 1, bg: 24'h222222, addr: 3599, hit: 1};
    tab[2] = '{x: 380, y: 240, pv: 1, bg: 24'h333333, addr: 0,    hit: 0};
    tab[3] = '{x: 319, y: 240, pv: 1, bg: 24'h444444, addr: 0,    hit: 0};
    tab[4] = '{x: 321, y: 241, pv: 1, bg: 24'h555555, addr: 61,   hit: 1};
    tab[5] = '{x: 320, y: 299, pv: 1, bg: 24'h666666, addr: 3540, hit: 1};
    tab[6] = '{x: 379, y: 240, pv: 1, bg: 24'h777777, addr: 59,   hit: 1};
    tab[7] = '{x: 350, y: 300, pv: 1, bg: 24'h888888, addr: 0,    hit: 0};
    tab[8] = '{x: 330, y: 250, pv: 0, bg: 24'h999999, addr: 0,    hit: 0};

    apply(1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
    idle_cyc(2);

    // Home position table
    foreach (tab[i])
      apply(0, 0, 0, 0, 0, tab[i].pv, tab[i].x, tab[i].y, tab[i].bg, 1, tab[i].addr, tab[i].hit);
    idle_cyc(2);

    // Mid-frame move is held until frame_start
    apply(0, 0, 1, 100, 50, 1, 320, 240, 24'hABCDEF, 1, 0, 1);
    tpix(100, 50, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
    tpix(159, 109, 3599, 1);
    tpix(160, 50, 0, 0);
    tpix(100, 50, 0, 1);
    idle_cyc(2);

    // Same-cycle bypass and clamping
    apply(0, 1, 1, 620, 470, 0, 0, 0, 24'h0, 0, 0, 0);
    tpix(639, 479, 559, 1);
    tpix(620, 470, 0, 1);
    apply(0, 1, 1, 700, 500, 0, 0, 0, 24'h0, 0, 0, 0);
    tpix(639, 479, 0, 1);
    tpix(638, 479, 0, 0);
    idle_cyc(2);

    // Reset mid-line flushes the pipeline and re-homes the cursor
    for (int i = 0; i < 4; i++) pix(630 + i, 479, 24'h0F0F00 + 24'(i));
    apply(1, 0, 0, 0, 0, 1, 320, 240, 24'h010203, 0, 0, 0);
    tpix(320, 240, 0, 1);
    tpix(379, 299, 3599, 1);
    idle_cyc(2);

`ifdef CURSOR_HIDE_TIMEOUT_EN
    apply(1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 0, 0, 0, 0, 24'h0, 0, 0, 0);
    tpix(320, 240, 0, 1);
    tpix(330, 245, 310, 1);
    apply(0, 1, 1, 10, 10, 0, 0, 0, 24'h0, 0, 0, 0);
    tpix(10, 10, 0, 1);
    tpix(20, 15, 310, 1);
    idle_cyc(2);
`endif

    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      rst = (r == 0);
      fs  = (r >= 1 && r <= 5);
      mv  = ($urandom_range(0, 9) == 0);
      mx  = $urandom_range(0, 1023);
      my  = $urandom_range(0, 1023);
      pv  = !fs && ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        px = $urandom_range(0, 1023);
        py = $urandom_range(0, 1023);
      end else begin
        px = ac_x + $urandom_range(0, 79) - 10;
        py = ac_y + $urandom_range(0, 79) - 10;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px > 1023) px = 1023;
        if (py > 1023) py = 1023;
      end
      apply(rst, fs, mv, mx, my, pv, px, py, 24'($urandom), 0, 0, 0);
    end
    idle_cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
